// File: rtl/gesture_confirm_filter.sv
// gesture_confirm_filter
// Debounces classifier results: a gesture is reported only after CONFIRM_COUNT
// consecutive passing windows agree on the same direction. The report is held
// on a valid/ready interface, and a cooldown follows each accepted report so
// that one physical swipe yields a single report.
//
// Optional feature macro: GESTURE_CONFIRM_TIMEOUT_EN
//   When defined, a candidate in CONFIRM is abandoned after TIMEOUT_CYCLES
//   consecutive cycles without an in_valid strobe. When undefined, no idle
//   counter exists and TIMEOUT_CYCLES has no effect.
module gesture_confirm_filter #(
    parameter int CONFIRM_COUNT   = 3,
    parameter int COOLDOWN_CYCLES = 1_200_000,
    parameter int TIMEOUT_CYCLES  = 6_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic       in_pass,
    input  logic [1:0] in_gesture,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [1:0] out_gesture,
    output logic       busy
);

    // A zero-cycle cooldown would give a zero-width counter, so keep at least one bit.
    localparam int CNT_W = $clog2(CONFIRM_COUNT + 1);
    localparam int CD_W  = (COOLDOWN_CYCLES > 0) ? $clog2(COOLDOWN_CYCLES + 1) : 1;

    // Agree count value that, incremented once more, completes a confirmation.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CONFIRM_COUNT - 1);
    localparam logic [CD_W-1:0]  CD_LOAD  = CD_W'(COOLDOWN_CYCLES);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_CONFIRM  = 2'd1;
    localparam logic [1:0] ST_PENDING  = 2'd2;
    localparam logic [1:0] ST_COOLDOWN = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [1:0]       cand_q, cand_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CD_W-1:0]  cd_q, cd_d;
    logic             out_valid_q, out_valid_d;
    logic [1:0]       out_gesture_q, out_gesture_d;
    logic             busy_q, busy_d;

`ifdef GESTURE_CONFIRM_TIMEOUT_EN
    localparam int TMO_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    logic [TMO_W-1:0] tmo_q, tmo_d;
`endif

    // Next-state logic: candidate tracking, handshake, cooldown and registered output values.
    always_comb begin
        state_d       = state_q;
        cand_d        = cand_q;
        cnt_d         = cnt_q;
        cd_d          = cd_q;
        out_gesture_d = out_gesture_q;
`ifdef GESTURE_CONFIRM_TIMEOUT_EN
        tmo_d         = tmo_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_pass) begin
                    cand_d = in_gesture;
                    cnt_d  = CNT_W'(1);
                    if (CONFIRM_COUNT == 1) begin
                        state_d = ST_PENDING;
                    end else begin
                        state_d = ST_CONFIRM;
                    end
`ifdef GESTURE_CONFIRM_TIMEOUT_EN
                    tmo_d = '0;
`endif
                end
            end

            ST_CONFIRM: begin
                if (in_valid) begin
`ifdef GESTURE_CONFIRM_TIMEOUT_EN
                    tmo_d = '0;
`endif
                    if (!in_pass) begin
                        cnt_d   = '0;
                        state_d = ST_IDLE;
                    end else if (in_gesture == cand_q) begin
                        if (cnt_q == CNT_LAST) begin
                            cnt_d   = '0;
                            state_d = ST_PENDING;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end else begin
                        cand_d = in_gesture;
                        cnt_d  = CNT_W'(1);
                    end
                end else begin
`ifdef GESTURE_CONFIRM_TIMEOUT_EN
                    if ((TIMEOUT_CYCLES > 0) && (tmo_q == TMO_LAST)) begin
                        tmo_d   = '0;
                        cnt_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        tmo_d = tmo_q + TMO_W'(1);
                    end
`endif
                end
            end

            ST_PENDING: begin
                if (out_ready) begin
                    if (COOLDOWN_CYCLES == 0) begin
                        state_d = ST_IDLE;
                    end else begin
                        cd_d    = CD_LOAD;
                        state_d = ST_COOLDOWN;
                    end
                end
            end

            ST_COOLDOWN: begin
                if (cd_q <= CD_W'(1)) begin
                    cd_d    = '0;
                    state_d = ST_IDLE;
                end else begin
                    cd_d = cd_q - CD_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        out_valid_d = (state_d == ST_PENDING);
        busy_d      = (state_d == ST_PENDING) || (state_d == ST_COOLDOWN);
        if ((state_d == ST_PENDING) && (state_q != ST_PENDING)) begin
            out_gesture_d = cand_d;
        end
    end

    // State and output registers; reset drops any pending report and clears all counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            cand_q        <= '0;
            cnt_q         <= '0;
            cd_q          <= '0;
            out_valid_q   <= 1'b0;
            out_gesture_q <= '0;
            busy_q        <= 1'b0;
`ifdef GESTURE_CONFIRM_TIMEOUT_EN
            tmo_q         <= '0;
`endif
        end else begin
            state_q       <= state_d;
            cand_q        <= cand_d;
            cnt_q         <= cnt_d;
            cd_q          <= cd_d;
            out_valid_q   <= out_valid_d;
            out_gesture_q <= out_gesture_d;
            busy_q        <= busy_d;
`ifdef GESTURE_CONFIRM_TIMEOUT_EN
            tmo_q         <= tmo_d;
`endif
        end
    end

    assign out_valid   = out_valid_q;
    assign out_gesture = out_gesture_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_gesture_confirm_filter.sv
// tb_gesture_confirm_filter
// Directed scenarios followed by a randomized phase. A behavioural model tracks
// the current run of agreeing gestures, an outstanding report and the cooldown
// time left; a compare process checks the DUT against it on every cycle.
module tb_gesture_confirm_filter;

    localparam int CONFIRM  = 3;
    localparam int COOLDOWN = 16;
    localparam int TIMEOUT  = 100;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_pass = 1'b0;
    logic [1:0] in_gesture = 2'd0;
    logic       out_ready = 1'b0;
    logic       out_valid;
    logic [1:0] out_gesture;
    logic       busy;

    int checks = 0;
    int passes = 0;

    // Behavioural model state.
    int runGesture   = 0;
    int runLength    = 0;
    int idleGap      = 0;
    int cooldownLeft = 0;
    bit pending      = 1'b0;
    int expGesture   = 0;
    bit modelLive    = 1'b0;

    // Observed handshakes on the DUT output.
    int xferCount = 0;
    int lastXfer  = -1;

    gesture_confirm_filter #(
        .CONFIRM_COUNT  (CONFIRM),
        .COOLDOWN_CYCLES(COOLDOWN),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_pass    (in_pass),
        .in_gesture (in_gesture),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_gesture(out_gesture),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input int expected);
        checks++;
        if (actual === 32'(expected)) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input bit v, input bit p, input logic [1:0] g);
        @(negedge clk);
        in_valid   = v;
        in_pass    = p;
        in_gesture = g;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, 1'b0, 2'd0);
        end
    endtask

    task automatic waitQuiet();
        int k;
        k = 0;
        out_ready = 1'b1;
        applyStimulus(1'b0, 1'b0, 2'd0);
        while ((busy || out_valid) && k < 200) begin
            applyStimulus(1'b0, 1'b0, 2'd0);
            k++;
        end
        checkOutput("quiet_bound", 32'(k < 200), 1);
    endtask

    // Reference model: advances one clock using the inputs present at the edge.
    always @(posedge clk) begin
        if (modelLive && !rst && out_valid && out_ready) begin
            xferCount++;
            lastXfer = int'(out_gesture);
        end
        if (rst) begin
            runGesture   = 0;
            runLength    = 0;
            idleGap      = 0;
            cooldownLeft = 0;
            pending      = 1'b0;
            expGesture   = 0;
            modelLive    = 1'b1;
        end else if (pending) begin
            if (out_ready) begin
                pending      = 1'b0;
                cooldownLeft = COOLDOWN;
            end
        end else if (cooldownLeft > 0) begin
            cooldownLeft--;
        end else if (in_valid) begin
            idleGap = 0;
            if (in_pass) begin
                if (runLength > 0 && int'(in_gesture) == runGesture) begin
                    runLength++;
                end else begin
                    runGesture = int'(in_gesture);
                    runLength  = 1;
                end
                if (runLength == CONFIRM) begin
                    pending    = 1'b1;
                    expGesture = runGesture;
                    runLength  = 0;
                end
            end else begin
                runLength = 0;
            end
        end else begin
`ifdef GESTURE_CONFIRM_TIMEOUT_EN
            if (runLength > 0) begin
                idleGap++;
                if (idleGap == TIMEOUT) begin
                    runLength = 0;
                end
            end
`endif
        end
    end

    // Per-cycle comparison of the DUT outputs with the model.
    always @(negedge clk) begin
        if (modelLive) begin
            checkOutput("out_valid", 32'(out_valid), int'(pending));
            checkOutput("busy", 32'(busy), int'(pending || cooldownLeft > 0));
            if (pending) begin
                checkOutput("out_gesture", 32'(out_gesture), expGesture);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int x0;
        int busyCount;
        int k;
        logic [1:0] g;

        // Reset state.
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("rst_out_valid", 32'(out_valid), 0);
        checkOutput("rst_busy", 32'(busy), 0);
        checkOutput("rst_out_gesture", 32'(out_gesture), 0);
        rst = 1'b0;
        idleCycles(2);

        // Scenario 1: three UP events, consumer always ready.
        $display("[TB] scenario 1");
        out_ready = 1'b1;
        x0 = xferCount;
        repeat (3) applyStimulus(1'b1, 1'b1, 2'd0);
        applyStimulus(1'b0, 1'b0, 2'd0);
        checkOutput("s1_valid_latency", 32'(out_valid), 1);
        checkOutput("s1_gesture", 32'(out_gesture), 0);
        applyStimulus(1'b0, 1'b0, 2'd0);
        checkOutput("s1_valid_dropped", 32'(out_valid), 0);
        waitQuiet();
        checkOutput("s1_xfers", 32'(xferCount - x0), 1);
        checkOutput("s1_xfer_value", 32'(lastXfer), 0);

        // Scenario 2: LEFT,LEFT,RIGHT,RIGHT,RIGHT.
        $display("[TB] scenario 2");
        x0 = xferCount;
        applyStimulus(1'b1, 1'b1, 2'd2);
        applyStimulus(1'b1, 1'b1, 2'd2);
        applyStimulus(1'b1, 1'b1, 2'd3);
        applyStimulus(1'b1, 1'b1, 2'd3);
        applyStimulus(1'b1, 1'b1, 2'd3);
        checkOutput("s2_no_early_output", 32'(out_valid), 0);
        applyStimulus(1'b0, 1'b0, 2'd0);
        checkOutput("s2_valid", 32'(out_valid), 1);
        checkOutput("s2_gesture", 32'(out_gesture), 3);
        waitQuiet();
        checkOutput("s2_xfers", 32'(xferCount - x0), 1);
        checkOutput("s2_xfer_value", 32'(lastXfer), 3);

        // Scenario 3: a failing window breaks the run.
        $display("[TB] scenario 3");
        x0 = xferCount;
        applyStimulus(1'b1, 1'b1, 2'd2);
        applyStimulus(1'b1, 1'b1, 2'd2);
        applyStimulus(1'b1, 1'b0, 2'd2);
        applyStimulus(1'b1, 1'b1, 2'd2);
        applyStimulus(1'b0, 1'b0, 2'd0);
        checkOutput("s3_no_output", 32'(out_valid), 0);
        checkOutput("s3_not_busy", 32'(busy), 0);
        applyStimulus(1'b1, 1'b1, 2'd2);
        applyStimulus(1'b1, 1'b1, 2'd2);
        applyStimulus(1'b0, 1'b0, 2'd0);
        checkOutput("s3_valid", 32'(out_valid), 1);
        checkOutput("s3_gesture", 32'(out_gesture), 2);
        waitQuiet();
        checkOutput("s3_xfers", 32'(xferCount - x0), 1);

        // Scenario 4: back-pressure, then cooldown and restart on first idle cycle.
        $display("[TB] scenario 4");
        x0 = xferCount;
        out_ready = 1'b0;
        repeat (3) applyStimulus(1'b1, 1'b1, 2'd1);
        for (int i = 0; i < 10; i++) begin
            applyStimulus((i == 1 || i == 3 || i == 5), 1'b1, 2'd0);
            checkOutput("s4_held_valid", 32'(out_valid), 1);
            checkOutput("s4_held_gesture", 32'(out_gesture), 1);
            checkOutput("s4_held_busy", 32'(busy), 1);
        end
        applyStimulus(1'b0, 1'b0, 2'd0);
        out_ready = 1'b1;
        busyCount = 0;
        k = 0;
        @(negedge clk);
        while (busy && k < 40) begin
            busyCount++;
            in_valid   = 1'b1;
            in_pass    = 1'b1;
            in_gesture = 2'd0;
            @(negedge clk);
            k++;
        end
        checkOutput("s4_cooldown_len", 32'(busyCount), COOLDOWN);
        in_valid   = 1'b1;
        in_pass    = 1'b1;
        in_gesture = 2'd3;
        applyStimulus(1'b1, 1'b1, 2'd3);
        applyStimulus(1'b1, 1'b1, 2'd3);
        applyStimulus(1'b0, 1'b0, 2'd0);
        checkOutput("s4_restart_valid", 32'(out_valid), 1);
        checkOutput("s4_restart_gesture", 32'(out_gesture), 3);
        waitQuiet();
        checkOutput("s4_xfers", 32'(xferCount - x0), 2);
        checkOutput("s4_last_xfer", 32'(lastXfer), 3);

        // Scenario 5: reset while a report is pending.
        $display("[TB] scenario 5");
        x0 = xferCount;
        out_ready = 1'b0;
        repeat (3) applyStimulus(1'b1, 1'b1, 2'd1);
        applyStimulus(1'b0, 1'b0, 2'd0);
        checkOutput("s5_pending", 32'(out_valid), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("s5_rst_valid", 32'(out_valid), 0);
        checkOutput("s5_rst_busy", 32'(busy), 0);
        checkOutput("s5_rst_gesture", 32'(out_gesture), 0);
        out_ready = 1'b1;
        applyStimulus(1'b1, 1'b1, 2'd0);
        applyStimulus(1'b1, 1'b1, 2'd0);
        idleCycles(3);
        checkOutput("s5_no_output", 32'(out_valid), 0);
        checkOutput("s5_xfers", 32'(xferCount - x0), 0);
        applyStimulus(1'b1, 1'b0, 2'd0);
        waitQuiet();

`ifdef GESTURE_CONFIRM_TIMEOUT_EN
        // Scenario 6: stale candidate abandoned after the idle timeout.
        $display("[TB] scenario 6");
        applyStimulus(1'b1, 1'b1, 2'd0);
        applyStimulus(1'b1, 1'b1, 2'd0);
        idleCycles(TIMEOUT);
        applyStimulus(1'b1, 1'b1, 2'd0);
        applyStimulus(1'b0, 1'b0, 2'd0);
        checkOutput("s6_timeout_no_output", 32'(out_valid), 0);
        applyStimulus(1'b1, 1'b0, 2'd0);
        applyStimulus(1'b1, 1'b1, 2'd0);
        applyStimulus(1'b1, 1'b1, 2'd0);
        idleCycles(TIMEOUT - 1);
        applyStimulus(1'b1, 1'b1, 2'd0);
        applyStimulus(1'b0, 1'b0, 2'd0);
        checkOutput("s6_short_gap_valid", 32'(out_valid), 1);
        checkOutput("s6_short_gap_gesture", 32'(out_gesture), 0);
        waitQuiet();
`endif

        // Randomized phase, biased towards repeated gestures so reports occur.
        $display("[TB] random phase");
        g = 2'd0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            rst       = ($urandom_range(0, 299) == 0);
            in_valid  = ($urandom_range(0, 1) == 1);
            in_pass   = ($urandom_range(0, 9) < 8);
            if ($urandom_range(0, 3) == 0) begin
                g = 2'($urandom_range(0, 3));
            end
            in_gesture = g;
            out_ready  = ($urandom_range(0, 9) < 6);
        end
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        idleCycles(2);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
